irq_source_conditioner: RTL and testbench

Sits directly upstream of the external interrupt controller and produces its `irq_source` vector.
- Synchronises raw asynchronous peripheral/pad interrupt lines into `hb_clk` and applies per-line polarity.
- Per line, either passes the level through or latches a rising-edge event into a sticky pending bit until software clears it.
- Mapped as a system peripheral on the same shared bus: `sys_share` / `sel`, registered `rdata`.

---
 rtl/irq_source_conditioner.sv | 100 ++++++++++
 tb/tb_irq_source_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_conditioner.sv
// Interrupt source conditioner: synchronises raw interrupt lines, applies polarity and
// level/edge mode, and exposes MODE/POLARITY/PENDING/STATUS registers on the shared bus.
package irq_source_conditioner_pkg;
    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } sys_peripheral_t;

    typedef struct packed {
        logic wen;
        logic ren;
    } sel_t;
endpackage

module irq_source_conditioner
    import irq_source_conditioner_pkg::*;
#(
    parameter int INT_NUM     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 hb_clk,
    input  logic                 rst_sync,
    input  sys_peripheral_t      sys_share,
    input  sel_t                 sel,
    output logic [31:0]          rdata,
    input  logic [INT_NUM-1:0]   irq_in,
    output logic [INT_NUM-1:0]   irq_source
);

    localparam logic [31:0] ADDR_MODE    = 32'h0;
    localparam logic [31:0] ADDR_POL     = 32'h4;
    localparam logic [31:0] ADDR_PENDING = 32'h8;
    localparam logic [31:0] ADDR_STATUS  = 32'hC;

    logic [SYNC_STAGES-1:0][INT_NUM-1:0] sync_q, sync_d;
    logic [INT_NUM-1:0] mode_q, mode_d;
    logic [INT_NUM-1:0] pol_q, pol_d;
    logic [INT_NUM-1:0] pend_q, pend_d;
    logic [INT_NUM-1:0] prev_q, prev_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [INT_NUM-1:0] sync_out;
    logic [INT_NUM-1:0] norm;
    logic [INT_NUM-1:0] edge_det;
    logic [INT_NUM-1:0] wbits;
    logic               wr_mode, wr_pol, wr_pend;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign norm     = sync_out ^ pol_q;
    assign edge_det = norm & ~prev_q;
    assign wbits    = sys_share.wdata[INT_NUM-1:0];
    assign wr_mode  = sel.wen && (sys_share.waddr == ADDR_MODE);
    assign wr_pol   = sel.wen && (sys_share.waddr == ADDR_POL);
    assign wr_pend  = sel.wen && (sys_share.waddr == ADDR_PENDING);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        mode_d = wr_mode ? wbits : mode_q;
        pol_d  = wr_pol  ? wbits : pol_q;
        // Reload prev with the new polarity so a polarity change cannot look like an edge.
        prev_d = wr_pol ? (sync_out ^ wbits) : norm;
        // Mode-to-level clear beats edge set, which beats W1C, so no event is lost.
        pend_d = ~(wr_mode ? ~wbits : '0) &
                 ((edge_det & mode_q) | (pend_q & ~(wr_pend ? wbits : '0)));

        rdata_d = rdata_q;
        if (sel.ren) begin
            case (sys_share.raddr)
                ADDR_MODE:    rdata_d = 32'(mode_q);
                ADDR_POL:     rdata_d = 32'(pol_q);
                ADDR_PENDING: rdata_d = 32'(pend_q);
                ADDR_STATUS:  rdata_d = 32'(norm);
                default:      rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge hb_clk) begin
        if (rst_sync) begin
            sync_q  <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync_q  <= sync_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            rdata_q <= rdata_d;
        end
    end

    assign irq_source = (mode_q & pend_q) | (~mode_q & norm);
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Directed bench for irq_source_conditioner (32-line instance plus an 8-line instance).
module tb_irq_source_conditioner;
    import irq_source_conditioner_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    sys_peripheral_t bus;
    sel_t            sel;
    logic [31:0]     irq_in;
    logic [31:0]     irq_src;
    logic [31:0]     rdata;
    logic [7:0]      irq_src8;
    logic [31:0]     rdata8;
    logic [31:0]     rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_source_conditioner #(.INT_NUM(32), .SYNC_STAGES(2)) dut (
        .hb_clk(clk), .rst_sync(rst), .sys_share(bus), .sel(sel),
        .rdata(rdata), .irq_in(irq_in), .irq_source(irq_src)
    );

    irq_source_conditioner #(.INT_NUM(8), .SYNC_STAGES(2)) dut8 (
        .hb_clk(clk), .rst_sync(rst), .sys_share(bus), .sel(sel),
        .rdata(rdata8), .irq_in(irq_in[7:0]), .irq_source(irq_src8)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.waddr = a;
        bus.wdata = d;
        sel.wen   = 1'b1;
        tick();
        sel.wen   = 1'b0;
    endtask

    task automatic rdreg(input logic [31:0] a, output logic [31:0] d);
        bus.raddr = a;
        sel.ren   = 1'b1;
        tick();
        sel.ren   = 1'b0;
        d = rdata;
    endtask

    initial begin
        bus    = '0;
        sel    = '0;
        irq_in = '0;
        tick(3);
        rst = 1'b0;

        chk("reset_src", irq_src, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_src8", {24'h0, irq_src8}, 32'h0);

        // Level mode default, exact 2-cycle latency
        irq_in[3] = 1'b1;
        tick();
        chk("lvl_rise_c1", irq_src, 32'h0);
        tick();
        chk("lvl_rise_c2", irq_src, 32'h8);
        rdreg(32'hC, rd);
        chk("status_read", rd, 32'h8);
        irq_in[3] = 1'b0;
        tick();
        chk("lvl_fall_c1", irq_src, 32'h8);
        tick();
        chk("lvl_fall_c2", irq_src, 32'h0);

        // Edge latch and clear
        wr(32'h0, 32'h1);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        chk("edge_c1", irq_src, 32'h0);
        tick();
        chk("edge_c2", irq_src, 32'h0);
        tick();
        chk("edge_c3", irq_src, 32'h1);
        tick(4);
        chk("edge_sticky", irq_src, 32'h1);
        rdreg(32'h8, rd);
        chk("pend_read", rd, 32'h1);
        wr(32'h8, 32'h0);
        chk("w1c_zero_noop", irq_src, 32'h1);
        wr(32'h8, 32'h1);
        chk("w1c_clear", irq_src, 32'h0);
        tick(3);

        // W1C colliding with a new edge: set wins
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick();
        wr(32'h8, 32'h1);
        chk("collide_set_wins", irq_src, 32'h1);
        rdreg(32'h8, rd);
        chk("collide_pend", rd, 32'h1);
        tick(3);

        // Polarity change without spurious edge
        wr(32'h0, 32'h20);
        wr(32'h4, 32'h20);
        tick(4);
        rdreg(32'h8, rd);
        chk("pol_no_glitch", rd, 32'h0);
        chk("pol_no_glitch_src", irq_src, 32'h0);
        irq_in[5] = 1'b1;
        tick(4);
        chk("pol_rise_ignored", irq_src, 32'h0);
        irq_in[5] = 1'b0;
        tick(3);
        chk("pol_fall_edge", irq_src, 32'h20);
        rdreg(32'h8, rd);
        chk("pol_fall_pend", rd, 32'h20);
        wr(32'h0, 32'h0);
        chk("pol_level_low", irq_src, 32'h20);
        rdreg(32'h8, rd);
        chk("mode0_clears_pend5", rd, 32'h0);
        wr(32'h4, 32'h0);
        tick(3);

        // Mode switch clears pending, then level tracking
        wr(32'h0, 32'h4);
        irq_in[2] = 1'b1;
        tick(4);
        chk("edge2_pend", irq_src, 32'h4);
        wr(32'h0, 32'h0);
        chk("mode_sw_level_hi", irq_src, 32'h4);
        rdreg(32'h8, rd);
        chk("mode_sw_pend_clr", rd, 32'h0);
        irq_in[2] = 1'b0;
        tick(2);
        chk("mode_sw_level_lo", irq_src, 32'h0);

        // Re-arm then reset
        wr(32'h0, 32'h4);
        wr(32'h4, 32'h10);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        tick(3);
        chk("rearm_pend", irq_src & 32'h4, 32'h4);
        rdreg(32'h4, rd);
        chk("rearm_pol", rd, 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_src", irq_src, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rdreg(32'h0, rd);
        chk("rst_mode", rd, 32'h0);
        rdreg(32'h4, rd);
        chk("rst_pol", rd, 32'h0);
        rdreg(32'h8, rd);
        chk("rst_pend", rd, 32'h0);

        // Bus corners
        wr(32'h0, 32'h3);
        wr(32'h10, 32'hFFFFFFFF);
        wr(32'hC, 32'hFFFFFFFF);
        rdreg(32'h0, rd);
        chk("corner_mode", rd, 32'h3);
        rdreg(32'h4, rd);
        chk("corner_pol", rd, 32'h0);
        rdreg(32'h8, rd);
        chk("corner_pend", rd, 32'h0);
        chk("corner_src", irq_src, 32'h0);
        rdreg(32'h0, rd);
        rdreg(32'h10, rd);
        chk("read_unmapped", rd, 32'h0);

        // Simultaneous write and read of MODE returns the old value; rdata holds
        bus.waddr = 32'h0;
        bus.wdata = 32'h7;
        bus.raddr = 32'h0;
        sel.wen   = 1'b1;
        sel.ren   = 1'b1;
        tick();
        sel = '0;
        chk("wr_rd_same_old", rdata, 32'h3);
        rdreg(32'h0, rd);
        chk("wr_rd_same_new", rd, 32'h7);
        bus.raddr = 32'h10;
        tick(2);
        chk("rdata_hold", rdata, 32'h7);

        // Narrow instance masks unimplemented bits
        wr(32'h0, 32'hFFFFFFFF);
        rdreg(32'h0, rd);
        chk("narrow_mode", rdata8, 32'h000000FF);
        chk("wide_mode", rd, 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
